// File: rtl/conv_encoder_r12_if.sv
// conv_encoder_r12_if: byte-in / codeword-out valid-ready bus of the rate-1/2 encoder
interface conv_encoder_r12_if;
  logic [7:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [15:0] out_data;
  logic out_valid;
  logic out_ready;
  modport master(output in_data, in_valid, out_ready, input in_ready, out_data, out_valid);
  modport slave(input in_data, in_valid, out_ready, output in_ready, out_data, out_valid);
endinterface

// File: rtl/conv_encoder_r12.sv
// conv_encoder_r12: bit-serial rate-1/2 K=3 (7,5) convolutional encoder, one 8-bit message per 16-bit codeword
module conv_encoder_r12 #(
  parameter bit CLEAR_PER_BLOCK = 1'b1
) (
  input  logic clk,
  input  logic rst,
  conv_encoder_r12_if.slave bus,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, ENC, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] msg;
  logic [2:0] cnt;
  logic s1, s2, c0, c1;
  always_comb begin
    c0 = msg[7] ^ s1 ^ s2;
    c1 = msg[7] ^ s2;
    state_nxt = (state == IDLE && bus.in_valid) ? ENC :
                (state == ENC && cnt == 3'd0) ? DONE :
                (state == DONE && bus.out_ready) ? IDLE : state;
  end
  // message shifts out MSB first; codeword shifts in so bit 7's pair lands in [15:14]
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      msg <= '0;
      cnt <= '0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      bus.out_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.in_valid) begin
        msg <= bus.in_data;
        cnt <= 3'd7;
        if (CLEAR_PER_BLOCK) begin
          s1 <= 1'b0;
          s2 <= 1'b0;
        end
      end else if (state == ENC) begin
        msg <= {msg[6:0], 1'b0};
        cnt <= cnt - 3'd1;
        s1 <= msg[7];
        s2 <= s1;
        bus.out_data <= {bus.out_data[13:0], c0, c1};
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_conv_encoder_r12.sv
// tb_conv_encoder_r12: directed checks of the (7,5) encoder with per-block clear and carried state
module tb_conv_encoder_r12;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy_a, busy_b;
  int n_cmp = 0;
  int n_err = 0;
  conv_encoder_r12_if ia();
  conv_encoder_r12_if ib();
  conv_encoder_r12 #(.CLEAR_PER_BLOCK(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ia), .busy(busy_a));
  conv_encoder_r12 #(.CLEAR_PER_BLOCK(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ib), .busy(busy_b));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input bit sel, input logic [7:0] d, output logic [15:0] w, output int lat);
    if (sel) begin ib.in_data = d; ib.in_valid = 1'b1; end
    else begin ia.in_data = d; ia.in_valid = 1'b1; end
    tick();
    ia.in_valid = 1'b0;
    ib.in_valid = 1'b0;
    lat = 0;
    while (!(sel ? ib.out_valid : ia.out_valid) && lat < 40) begin
      tick();
      lat++;
    end
    w = sel ? ib.out_data : ia.out_data;
  endtask

  task automatic handoff(input bit sel);
    if (sel) ib.out_ready = 1'b1; else ia.out_ready = 1'b1;
    tick();
    ia.out_ready = 1'b0;
    ib.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    n_cmp++; if (ia.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", ia.in_ready); end
    n_cmp++; if (ia.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", ia.out_valid); end
    n_cmp++; if (ia.out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got %h want 0000", ia.out_data); end
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_cmp++; if (ib.out_data !== 16'h0000 || ib.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_b got data %h ready %b want 0000 1", ib.out_data, ib.in_ready); end
  endtask

  task automatic test_zero();
    logic [15:0] w;
    int lat;
    run(1'b0, 8'h00, w, lat);
    n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL zero_word got %h want 0000", w); end
    n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL zero_latency got %0d want 8", lat); end
    repeat (3) tick();
    n_cmp++; if (ia.out_valid !== 1'b1 || busy_a !== 1'b1) begin n_err++; $display("FAIL zero_hold got valid %b busy %b want 1 1", ia.out_valid, busy_a); end
    handoff(1'b0);
    n_cmp++; if (ia.out_valid !== 1'b0 || ia.in_ready !== 1'b1) begin n_err++; $display("FAIL zero_handoff got valid %b ready %b want 0 1", ia.out_valid, ia.in_ready); end
  endtask

  task automatic test_patterns();
    logic [7:0] din [3] = '{8'hFF, 8'h80, 8'hAA};
    logic [15:0] exp_w [3] = '{16'hDAAA, 16'hEC00, 16'hE222};
    logic [15:0] w;
    int lat;
    for (int i = 0; i < 3; i++) begin
      run(1'b0, din[i], w, lat);
      n_cmp++; if (w !== exp_w[i]) begin n_err++; $display("FAIL pattern_%h got %h want %h", din[i], w, exp_w[i]); end
      n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL pattern_%h_latency got %0d want 8", din[i], lat); end
      handoff(1'b0);
    end
  endtask

  task automatic test_carry();
    logic [15:0] w;
    int lat;
    run(1'b1, 8'hFF, w, lat);
    n_cmp++; if (w !== 16'hDAAA) begin n_err++; $display("FAIL carry_first got %h want DAAA", w); end
    handoff(1'b1);
    run(1'b1, 8'h00, w, lat);
    n_cmp++; if (w !== 16'h7000) begin n_err++; $display("FAIL carry_second got %h want 7000", w); end
    handoff(1'b1);
    run(1'b0, 8'hFF, w, lat);
    handoff(1'b0);
    run(1'b0, 8'h00, w, lat);
    n_cmp++; if (w !== 16'h0000) begin n_err++; $display("FAIL clear_second got %h want 0000", w); end
    handoff(1'b0);
  endtask

  task automatic test_back_to_back_backpressure();
    logic [15:0] w;
    int lat;
    int bad;
    run(1'b0, 8'h80, w, lat);
    ia.in_data = 8'hFF;
    ia.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ia.out_data !== 16'hEC00 || ia.out_valid !== 1'b1 || ia.in_ready !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_stable got %0d bad cycles want 0", bad); end
    handoff(1'b0);
    n_cmp++; if (ia.in_ready !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL stall_release got ready %b busy %b want 1 0", ia.in_ready, busy_a); end
    tick();
    ia.in_valid = 1'b0;
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL held_byte_accept got busy %b want 1", busy_a); end
    lat = 0;
    while (!ia.out_valid && lat < 40) begin tick(); lat++; end
    n_cmp++; if (ia.out_data !== 16'hDAAA || lat !== 8) begin n_err++; $display("FAIL held_byte_word got %h lat %0d want DAAA 8", ia.out_data, lat); end
    handoff(1'b0);
  endtask

  task automatic test_abort();
    logic [15:0] w;
    int lat;
    int seen;
    ia.in_data = 8'hFF;
    ia.in_valid = 1'b1;
    tick();
    ia.in_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    n_cmp++; if (ia.in_ready !== 1'b1 || busy_a !== 1'b0 || ia.out_data !== 16'h0000) begin n_err++; $display("FAIL abort_idle got ready %b busy %b data %h want 1 0 0000", ia.in_ready, busy_a, ia.out_data); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ia.out_valid !== 1'b0) seen++; end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_no_valid got %0d valid cycles want 0", seen); end
    run(1'b0, 8'h80, w, lat);
    n_cmp++; if (w !== 16'hEC00 || lat !== 8) begin n_err++; $display("FAIL abort_next got %h lat %0d want EC00 8", w, lat); end
    handoff(1'b0);
  endtask

  initial begin
    ia.in_data = '0; ia.in_valid = 1'b0; ia.out_ready = 1'b0;
    ib.in_data = '0; ib.in_valid = 1'b0; ib.out_ready = 1'b0;
    test_reset();
    test_carry();
    test_zero();
    test_patterns();
    test_back_to_back_backpressure();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
